// File: rtl/bomberman_pkg.sv
// Shared definitions for the bomberman keyboard front-end: scan codes, receiver states
// and the scan-code to held-key lookup.
package bomberman_pkg;

    localparam logic [7:0] SC_Z     = 8'h1A;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_Q     = 8'h15;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Bit positions of the held-key vector
    localparam int unsigned KEY_J1_UP    = 0;
    localparam int unsigned KEY_J1_DOWN  = 1;
    localparam int unsigned KEY_J1_LEFT  = 2;
    localparam int unsigned KEY_J1_RIGHT = 3;
    localparam int unsigned KEY_J2_UP    = 4;
    localparam int unsigned KEY_J2_DOWN  = 5;
    localparam int unsigned KEY_J2_LEFT  = 6;
    localparam int unsigned KEY_J2_RIGHT = 7;
    localparam int unsigned NUM_KEYS     = 8;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} ps2_state_t;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } key_hit_t;

    // The extended prefix is part of the key identity: 1A with ext=1 or 75 with ext=0 miss.
    function automatic key_hit_t key_lookup(input logic [7:0] code, input logic ext);
        key_hit_t r;
        r.hit = 1'b1;
        r.idx = 3'd0;
        case ({ext, code})
            {1'b0, SC_Z}:     r.idx = 3'(KEY_J1_UP);
            {1'b0, SC_S}:     r.idx = 3'(KEY_J1_DOWN);
            {1'b0, SC_Q}:     r.idx = 3'(KEY_J1_LEFT);
            {1'b0, SC_D}:     r.idx = 3'(KEY_J1_RIGHT);
            {1'b1, SC_UP}:    r.idx = 3'(KEY_J2_UP);
            {1'b1, SC_DOWN}:  r.idx = 3'(KEY_J2_DOWN);
            {1'b1, SC_LEFT}:  r.idx = 3'(KEY_J2_LEFT);
            {1'b1, SC_RIGHT}: r.idx = 3'(KEY_J2_RIGHT);
            default:          r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_joueurs_if.sv
// Keyboard-side PS/2 lines plus the decoded player levels and status pulses.
interface ps2_joueurs_if;

    logic ps2_clk;
    logic ps2_data;
    logic j1_up;
    logic j1_down;
    logic j1_left;
    logic j1_right;
    logic j2_up;
    logic j2_down;
    logic j2_left;
    logic j2_right;
    logic byte_ok;
    logic frame_err;

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output j1_up,
        output j1_down,
        output j1_left,
        output j1_right,
        output j2_up,
        output j2_down,
        output j2_left,
        output j2_right,
        output byte_ok,
        output frame_err
    );

    modport master (
        output ps2_clk,
        output ps2_data,
        input  j1_up,
        input  j1_down,
        input  j1_left,
        input  j1_right,
        input  j2_up,
        input  j2_down,
        input  j2_left,
        input  j2_right,
        input  byte_ok,
        input  frame_err
    );

endinterface

// File: rtl/ps2_joueurs_rx.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, frame FSM, timeout and parity check.
// o_byte_ok / o_frame_err are single-cycle strobes valid in the CHECK/IDLE/RECV cycle itself.
module ps2_rx
    import bomberman_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_byte_ok,
    output logic       o_frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fall;

    ps2_state_t r_state;
    ps2_state_t w_state_next;
    logic [3:0]    r_bitcnt;
    logic [3:0]    w_bitcnt_next;
    logic [10:0]   r_shreg;
    logic [10:0]   w_shreg_next;
    logic [TW-1:0] r_tmo;
    logic [TW-1:0] w_tmo_next;
    logic          r_mask;
    logic          w_mask_next;
    logic          w_tmo_hit;

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_data};
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_tmo_hit = (r_tmo >= TW'(TIMEOUT_CYC - 1));

    // After a bad start bit the remaining edges of that frame are ignored until the
    // line has been quiet for TIMEOUT_CYC, so one stray frame yields one frame_err.
    always_comb begin
        w_state_next  = r_state;
        w_bitcnt_next = r_bitcnt;
        w_shreg_next  = r_shreg;
        w_mask_next   = r_mask;
        w_tmo_next    = '0;
        o_byte_ok     = 1'b0;
        o_frame_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_mask) begin
                    if (!w_fall) begin
                        if (w_tmo_hit) begin
                            w_mask_next = 1'b0;
                        end else begin
                            w_tmo_next = r_tmo + TW'(1);
                        end
                    end
                end else if (w_fall) begin
                    if (!w_dat_s) begin
                        w_state_next  = RECV;
                        w_bitcnt_next = 4'd0;
                        w_shreg_next  = {w_dat_s, r_shreg[10:1]};
                    end else begin
                        o_frame_err = 1'b1;
                        w_mask_next = 1'b1;
                    end
                end
            end
            RECV: begin
                if (w_fall) begin
                    w_shreg_next  = {w_dat_s, r_shreg[10:1]};
                    w_bitcnt_next = r_bitcnt + 4'd1;
                    if (r_bitcnt == 4'd9) begin
                        w_state_next = CHECK;
                    end
                end else if (w_tmo_hit) begin
                    o_frame_err  = 1'b1;
                    w_state_next = IDLE;
                end else begin
                    w_tmo_next = r_tmo + TW'(1);
                end
            end
            CHECK: begin
                w_state_next = IDLE;
                // shreg = {stop, parity, data[7:0], start}
                if (r_shreg[10] && (^r_shreg[9:1]) && !r_shreg[0]) begin
                    o_byte_ok = 1'b1;
                end else begin
                    o_frame_err = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_bitcnt <= 4'd0;
            r_shreg  <= '0;
            r_tmo    <= '0;
            r_mask   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_bitcnt <= w_bitcnt_next;
            r_shreg  <= w_shreg_next;
            r_tmo    <= w_tmo_next;
            r_mask   <= w_mask_next;
        end
    end

    assign o_byte = r_shreg[8:1];

endmodule

// File: rtl/ps2_joueurs.sv
// PS/2 keyboard front-end for two players: make/break decoder driving eight held-key levels.
// Levels and status pulses are registered together, so a level changes with its byte_ok.
module ps2_joueurs
    import bomberman_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           reset,
    ps2_joueurs_if.slave   bus
);

    logic [7:0]          w_byte;
    logic                w_byte_ok;
    logic                w_frame_err;
    key_hit_t            w_hit;
    logic [NUM_KEYS-1:0] r_keys;
    logic                r_ext;
    logic                r_brk;
    logic                r_byte_ok;
    logic                r_frame_err;

    ps2_rx #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .i_ps2_clk   (bus.ps2_clk),
        .i_ps2_data  (bus.ps2_data),
        .o_byte      (w_byte),
        .o_byte_ok   (w_byte_ok),
        .o_frame_err (w_frame_err)
    );

    assign w_hit = key_lookup(w_byte, r_ext);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_keys      <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_byte_ok   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_ok   <= w_byte_ok;
            r_frame_err <= w_frame_err;
            if (w_frame_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_ok) begin
                if (w_byte == SC_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == SC_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    if (w_hit.hit) begin
                        r_keys[w_hit.idx] <= ~r_brk;
                    end
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                end
            end
        end
    end

    assign bus.j1_up     = r_keys[KEY_J1_UP];
    assign bus.j1_down   = r_keys[KEY_J1_DOWN];
    assign bus.j1_left   = r_keys[KEY_J1_LEFT];
    assign bus.j1_right  = r_keys[KEY_J1_RIGHT];
    assign bus.j2_up     = r_keys[KEY_J2_UP];
    assign bus.j2_down   = r_keys[KEY_J2_DOWN];
    assign bus.j2_left   = r_keys[KEY_J2_LEFT];
    assign bus.j2_right  = r_keys[KEY_J2_RIGHT];
    assign bus.byte_ok   = r_byte_ok;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_joueurs.sv
// Bench for ps2_joueurs: PS/2 frame driver, pulse monitor and a scan-code level model.
module tb_ps2_joueurs;

    localparam int unsigned TMO  = 300;
    localparam int unsigned SYNC = 2;
    localparam logic [7:0] KEY_CODE [8] = '{8'h1A, 8'h1B, 8'h15, 8'h23,
                                            8'h75, 8'h72, 8'h6B, 8'h74};

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    ps2_joueurs_if bus ();

    ps2_joueurs #(
        .TIMEOUT_CYC (TMO),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] keys;
    assign keys = {bus.j2_right, bus.j2_left, bus.j2_down, bus.j2_up,
                   bus.j1_right, bus.j1_left, bus.j1_down, bus.j1_up};

    // Pulse monitor, sampled mid-cycle
    int         n_ok = 0;
    int         n_err = 0;
    int         last_ok_cyc = -1;
    logic [7:0] keys_prev = '0;
    logic [7:0] keys_at_ok = '0;
    logic [7:0] keys_before_ok = '0;
    always @(negedge clk) begin
        if (bus.byte_ok === 1'b1) begin
            n_ok           <= n_ok + 1;
            last_ok_cyc    <= cyc;
            keys_at_ok     <= keys;
            keys_before_ok <= keys_prev;
        end
        if (bus.frame_err === 1'b1) n_err <= n_err + 1;
        keys_prev <= keys;
    end

    // Reference model: held keys from the make/break rules
    logic [7:0] m_keys = '0;
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    int         exp_ok = 0;
    int         exp_err = 0;
    int         stop_cyc = 0;

    task automatic model_byte(input logic [7:0] b);
        exp_ok++;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            for (int i = 0; i < 8; i++)
                if (b == KEY_CODE[i] && m_ext == (i >= 4 ? 1'b1 : 1'b0)) m_keys[i] = ~m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_err();
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int first, input int last,
                             input int half);
        for (int i = first; i <= last; i++) begin
            bus.ps2_data = bits[i];
            step(half);
            bus.ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            step(half);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad);
        send_bits(frame_bits(b, bad), 0, 10, int'($urandom_range(6, 14)));
        step(20);
        if (bad) model_err();
        else model_byte(b);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++;
        if ({keys, bus.byte_ok, bus.frame_err} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=000", {keys, bus.byte_ok, bus.frame_err});
        end
        reset = 1'b0;
        step(5);
        checks++;
        if (n_ok + n_err !== 0) begin
            failures++;
            $display("FAIL reset_quiet pulses got=%0d want=0", n_ok + n_err);
        end
    endtask

    task automatic test_single_make();
        send_frame(8'h1A, 1'b0);
        checks++;
        if (last_ok_cyc - stop_cyc !== int'(SYNC) + 2) begin
            failures++;
            $display("FAIL latency got=%0d want=%0d", last_ok_cyc - stop_cyc, SYNC + 2);
        end
        checks++;
        if (keys_before_ok !== 8'h00 || keys_at_ok !== 8'h01) begin
            failures++;
            $display("FAIL level_with_ok got=%h/%h want=00/01", keys_before_ok, keys_at_ok);
        end
        checks++;
        if (keys !== 8'h01 || n_ok !== exp_ok) begin
            failures++;
            $display("FAIL make_1a keys=%h ok=%0d want=01 ok=%0d", keys, n_ok, exp_ok);
        end
    endtask

    task automatic test_make_break();
        send_frame(8'h1B, 1'b0);
        send_frame(8'h23, 1'b0);
        checks++;
        if (keys !== m_keys) begin
            failures++;
            $display("FAIL multi_make keys got=%h want=%h", keys, m_keys);
        end
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1A, 1'b0);
        checks++;
        if (keys !== m_keys || keys[0] !== 1'b0) begin
            failures++;
            $display("FAIL break_1a keys got=%h want=%h", keys, m_keys);
        end
    endtask

    task automatic test_extended();
        int ok0;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++;
        if (keys !== m_keys || keys[4] !== 1'b1) begin
            failures++;
            $display("FAIL ext_make keys got=%h want=%h", keys, m_keys);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        checks++;
        if (keys !== m_keys || keys[4] !== 1'b0) begin
            failures++;
            $display("FAIL ext_break keys got=%h want=%h", keys, m_keys);
        end
        ok0 = n_ok;
        send_frame(8'h75, 1'b0);
        checks++;
        if (keys !== m_keys || n_ok - ok0 !== 1) begin
            failures++;
            $display("FAIL keypad8 keys=%h okdelta=%0d want=%h 1", keys, n_ok - ok0, m_keys);
        end
    endtask

    task automatic test_parity_err();
        int ok0;
        int err0;
        ok0  = n_ok;
        err0 = n_err;
        send_frame(8'h1A, 1'b1);
        checks++;
        if (n_err - err0 !== 1 || n_ok - ok0 !== 0 || keys[0] !== 1'b0) begin
            failures++;
            $display("FAIL parity errdelta=%0d okdelta=%0d j1_up=%b want=1 0 0",
                     n_err - err0, n_ok - ok0, keys[0]);
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'($urandom), 1'b1);
        send_frame(8'h74, 1'b0);
        checks++;
        if (keys !== m_keys || keys[7] !== 1'b0) begin
            failures++;
            $display("FAIL ext_cleared keys got=%h want=%h", keys, m_keys);
        end
    endtask

    task automatic test_timeout();
        int ok0;
        int err0;
        send_frame(8'hF0, 1'b0);
        send_frame(8'h23, 1'b0);
        ok0  = n_ok;
        err0 = n_err;
        send_bits(frame_bits(8'h23, 1'b0), 0, 4, 8);
        step(TMO + 40);
        model_err();
        checks++;
        if (n_err - err0 !== 1 || n_ok - ok0 !== 0) begin
            failures++;
            $display("FAIL timeout errdelta=%0d okdelta=%0d want=1 0", n_err - err0, n_ok - ok0);
        end
        send_frame(8'h23, 1'b0);
        checks++;
        if (keys !== m_keys || keys[3] !== 1'b1) begin
            failures++;
            $display("FAIL after_timeout keys got=%h want=%h", keys, m_keys);
        end
    endtask

    task automatic test_reset_mid_frame();
        int ok0;
        int err0;
        send_frame(8'h1A, 1'b0);
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        checks++;
        if (keys[0] !== 1'b1 || keys[6] !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset keys got=%h want=j1_up,j2_left set", keys);
        end
        send_bits(frame_bits(8'h15, 1'b0), 0, 3, 8);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++;
        if ({keys, bus.byte_ok, bus.frame_err} !== 10'd0) begin
            failures++;
            $display("FAIL mid_reset outputs got=%h want=000", {keys, bus.byte_ok, bus.frame_err});
        end
        m_keys = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        ok0  = n_ok;
        err0 = n_err;
        send_bits(frame_bits(8'h15, 1'b0), 4, 10, 8);
        step(TMO + 40);
        checks++;
        if (n_err - err0 > 1 || n_ok - ok0 !== 0) begin
            failures++;
            $display("FAIL stray_edges errdelta=%0d okdelta=%0d want<=1 0",
                     n_err - err0, n_ok - ok0);
        end
        // Re-baseline: the stray tail may legitimately produce zero or one error
        exp_ok  = n_ok;
        exp_err = n_err;
        send_frame(8'h15, 1'b0);
        checks++;
        if (keys !== 8'h04 || keys !== m_keys) begin
            failures++;
            $display("FAIL after_reset keys got=%h want=04", keys);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [13];
        logic [7:0] b;
        logic       bad;
        pool = '{8'h1A, 8'h1B, 8'h15, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h00};
        for (int n = 0; n < 80; n++) begin
            b = pool[$urandom_range(0, 12)];
            if (b == 8'h00) b = 8'($urandom);
            bad = ($urandom_range(0, 11) == 0);
            send_frame(b, bad);
            checks++;
            if (keys !== m_keys) begin
                failures++;
                $display("FAIL rand[%0d] byte=%h bad=%b keys got=%h want=%h", n, b, bad, keys,
                         m_keys);
            end
            checks++;
            if (n_ok !== exp_ok || n_err !== exp_err) begin
                failures++;
                $display("FAIL rand_pulses[%0d] ok=%0d err=%0d want ok=%0d err=%0d", n, n_ok,
                         n_err, exp_ok, exp_err);
            end
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        test_reset();
        test_single_make();
        test_make_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
